// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send, device-clocked shift, ack check.
// Optional resend on nack/timeout is enabled with `define PS2_TX_RESEND_EN.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int MAX_RETRY      = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       timeout,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
`ifdef PS2_TX_RESEND_EN
   localparam int RETRY_LIMIT = MAX_RETRY;
`else
   localparam int RETRY_LIMIT = 0;
`endif

   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SEND,
      ACK,
      WAIT_IDLE,
      DONE
   } state_t;

   state_t             state;
   logic [9:0]         frame;
   logic [3:0]         idx;
   logic [CNT_W-1:0]   cnt;
   logic [RETRY_W-1:0] retries;
   logic               clk_meta, clk_sync, clk_prev;
   logic               data_meta, data_sync;
   logic               fall;
   logic               retry_left;

   assign fall       = clk_prev & ~clk_sync;
   assign retry_left = (retries != RETRY_W'(RETRY_LIMIT));
   assign busy       = ~tx_ready;

   // NOTE: every register here is written with <= so all branches see pre-edge values;
   // synchroniser flops reset to the idle-high line level so reset release never looks like a fall.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         frame       <= '0;
         idx         <= '0;
         cnt         <= '0;
         retries     <= '0;
         clk_meta    <= 1'b1;
         clk_sync    <= 1'b1;
         clk_prev    <= 1'b1;
         data_meta   <= 1'b1;
         data_sync   <= 1'b1;
         tx_ready    <= 1'b1;
         done        <= 1'b0;
         ack_ok      <= 1'b0;
         timeout     <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         clk_meta  <= ps2_clk_in;
         clk_sync  <= clk_meta;
         clk_prev  <= clk_sync;
         data_meta <= ps2_data_in;
         data_sync <= data_meta;
         done      <= 1'b0;

         case (state)
            IDLE: begin
               if (tx_valid) begin
                  frame       <= {1'b1, ~^tx_data, tx_data};
                  ack_ok      <= 1'b0;
                  timeout     <= 1'b0;
                  retries     <= '0;
                  tx_ready    <= 1'b0;
                  ps2_clk_oe  <= 1'b1;
                  ps2_data_oe <= 1'b0;
                  cnt         <= '0;
                  idx         <= '0;
                  state       <= INHIBIT;
               end
            end

            INHIBIT: begin
               if (cnt == INHIBIT_LAST) begin
                  ps2_data_oe <= 1'b1;
                  state       <= REQ;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            REQ: begin
               ps2_clk_oe <= 1'b0;
               cnt        <= '0;
               state      <= SEND;
            end

            SEND, ACK, WAIT_IDLE: begin
               // Timeout outranks a fall arriving in the same cycle.
               if (cnt == TIMEOUT_LAST) begin
                  ps2_data_oe <= 1'b0;
                  ack_ok      <= 1'b0;
                  cnt         <= '0;
                  idx         <= '0;
                  if (retry_left) begin
                     retries    <= retries + 1'b1;
                     ps2_clk_oe <= 1'b1;
                     state      <= INHIBIT;
                  end else begin
                     ps2_clk_oe <= 1'b0;
                     timeout    <= 1'b1;
                     done       <= 1'b1;
                     state      <= DONE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
                  if (state == SEND && fall) begin
                     ps2_data_oe <= ~frame[idx];
                     if (idx == 4'd9) begin
                        state <= ACK;
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end else if (state == ACK && fall) begin
                     if (!data_sync) begin
                        ack_ok <= 1'b1;
                        state  <= WAIT_IDLE;
                     end else if (retry_left) begin
                        retries    <= retries + 1'b1;
                        ps2_clk_oe <= 1'b1;
                        cnt        <= '0;
                        idx        <= '0;
                        state      <= INHIBIT;
                     end else begin
                        ack_ok <= 1'b0;
                        state  <= WAIT_IDLE;
                     end
                  end else if (state == WAIT_IDLE && clk_sync && data_sync) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end

            DONE: begin
               tx_ready <= 1'b1;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
